// File: rtl/tinymips_pkg.sv
// Shared TinyMIPS definitions: word width, boot FSM encoding and the opcode
// constants used by the boot RAM and by program-assembly helpers in benches.
// The FILL state is only reachable when TINYMIPS_BOOT_ZERO_FILL_EN is defined.
package tinymips_pkg;

  localparam int WORD_W = 16;

  // Boot front-end states: stream words in, optionally clear the tail, then run.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } boot_state_t;

  // Major opcode field, instruction bits [15:12].
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;

  // Packs an immediate-format word: opcode, rs, rt, 6-bit immediate.
  function automatic logic [WORD_W-1:0] mk_itype(
    input logic [3:0] op,
    input logic [2:0] rs,
    input logic [2:0] rt,
    input logic [5:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/boot_ram_array.sv
// Single-port synchronous RAM with registered, read-first output.
// Contents are never reset so the array maps onto block RAM.
module boot_ram_array
  import tinymips_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2 ** SIZE,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [SIZE-1:0]  addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;

  // Write and read share the address; the read returns the pre-write word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout_reg <= mem[addr];
  end

  assign dout = dout_reg;

endmodule

// File: rtl/tinymips_boot_ram.sv
// TinyMIPS memory responder with a streaming boot loader in front of the RAM.
// The CPU is held in reset while words are loaded from address 0 upward.
// Define TINYMIPS_BOOT_ZERO_FILL_EN to clear the unloaded tail before release.
module tinymips_boot_ram
  import tinymips_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 2 ** SIZE,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SIZE-1:0]  addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             cpu_rst,
  output logic             load_done,
  output logic             load_ovf
);

  localparam logic [SIZE-1:0] PTR_MAX = SIZE'(DEPTH - 1);

  boot_state_t      state_reg, state_next;
  logic [SIZE-1:0]  ptr_reg, ptr_next;
  logic             ovf_reg, ovf_next;
  logic             ld_ready_reg;
  logic             cpu_rst_reg;
  logic             dout_en_reg;
  logic             accept;
  logic             ram_we;
  logic [SIZE-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  assign accept = ld_valid & ld_ready_reg & (state_reg == ST_LOAD);

  // Next state and RAM port steering: loader owns the port in LOAD/FILL, CPU in RUN.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    ovf_next   = ovf_reg;
    ram_we     = 1'b0;
    ram_addr   = ptr_reg;
    ram_din    = ld_data;
    case (state_reg)
      ST_LOAD: begin
        if (accept) begin
          ram_we = 1'b1;
          // The pointer saturates at the top word instead of wrapping.
          if (ptr_reg != PTR_MAX) begin
            ptr_next = ptr_reg + SIZE'(1);
          end
          if (ld_last) begin
`ifdef TINYMIPS_BOOT_ZERO_FILL_EN
            // Last word in the top slot leaves nothing to clear.
            state_next = (ptr_reg == PTR_MAX) ? ST_RUN : ST_FILL;
`else
            state_next = ST_RUN;
`endif
          end else if (ptr_reg == PTR_MAX) begin
            ovf_next   = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
`ifdef TINYMIPS_BOOT_ZERO_FILL_EN
      ST_FILL: begin
        ram_we  = 1'b1;
        ram_din = '0;
        if (ptr_reg == PTR_MAX) begin
          state_next = ST_RUN;
        end else begin
          ptr_next = ptr_reg + SIZE'(1);
        end
      end
`endif
      ST_RUN: begin
        ram_we   = we;
        ram_addr = addr;
        ram_din  = din;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
    // No write of any kind lands while reset is asserted.
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  // Boot FSM state plus registered handshake, CPU reset and output-enable flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_LOAD;
      ptr_reg      <= '0;
      ovf_reg      <= 1'b0;
      ld_ready_reg <= 1'b0;
      cpu_rst_reg  <= 1'b1;
      dout_en_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      ovf_reg      <= ovf_next;
      ld_ready_reg <= (state_next == ST_LOAD);
      cpu_rst_reg  <= (state_next != ST_RUN);
      dout_en_reg  <= (state_reg == ST_RUN);
    end
  end

  boot_ram_array #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // The read register is not reset, so gate it until a RUN-cycle read has landed.
  assign dout      = dout_en_reg ? ram_dout : '0;
  assign ld_ready  = ld_ready_reg;
  assign cpu_rst   = cpu_rst_reg;
  assign load_done = (state_reg == ST_RUN);
  assign load_ovf  = ovf_reg;

endmodule
